// File: rtl/midi_merge_arbiter.sv
// MIDI merge: N byte streams share one output. Whole messages are granted round-robin,
// running status is re-inserted per input, and realtime bytes cut in between message bytes.
module midi_merge_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       en_i,
  input  logic       take_i,
  output logic       rt_req_o,
  output logic       nrt_vld_o,
  output logic       is_stat_o,
  output logic [7:0] rs_o
);
  logic       is_rt;
  logic [7:0] rs_q, rs_d;

  assign is_rt     = data_i >= 8'hF8;
  assign rt_req_o  = valid_i && en_i && is_rt;
  assign nrt_vld_o = valid_i && !is_rt;
  assign is_stat_o = data_i[7] && !is_rt;
  assign rs_o      = rs_q;

  // Channel status is remembered; system common / sysex cancels running status.
  always_comb begin
    rs_d = rs_q;
    if (take_i && is_stat_o) rs_d = (data_i < 8'hF0) ? data_i : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rs_q <= 8'h00;
    else        rs_q <= rs_d;
  end
endmodule

module midi_merge_arbiter #(
  parameter int              N       = 4,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   en_mask,
  input  logic [8*N-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [7:0]     out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic           err_timeout
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INSERT, S_FWD, S_SYSEX} state_t;

  function automatic logic [1:0] data_need(input logic [7:0] s);
    data_need = 2'd0;
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: data_need = 2'd2;
      4'hC, 4'hD:                   data_need = 2'd1;
      4'hF:
        case (s[3:0])
          4'h1, 4'h3: data_need = 2'd1;
          4'h2:       data_need = 2'd2;
          default:    data_need = 2'd0;
        endcase
      default: data_need = 2'd0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d, rr_q, rr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                err_q, err_d;
  logic [7:0]          od_q, od_d;
  logic                ov_q, ov_d;

  logic [N-1:0][7:0]   din, rs;
  logic [N-1:0]        rt_req, nrt_vld, is_stat, rdy;
  logic                can_load, ld, rt_hit, found, taken, release_g;
  logic [7:0]          ld_byte;
  logic [IW-1:0]       rt_idx, sel, cand;

  assign din = in_data;

  for (genvar g = 0; g < N; g++) begin : g_lane
    midi_merge_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_i   (din[g]),
      .valid_i  (in_valid[g]),
      .en_i     (en_mask[g]),
      .take_i   (in_ready[g]),
      .rt_req_o (rt_req[g]),
      .nrt_vld_o(nrt_vld[g]),
      .is_stat_o(is_stat[g]),
      .rs_o     (rs[g])
    );
  end

  always_comb begin
    state_d = state_q; grant_d = grant_q; gidx_d = gidx_q; rr_d = rr_q;
    cnt_d = cnt_q; to_d = to_q; err_d = 1'b0;
    ld = 1'b0; ld_byte = od_q; rdy = '0;
    rt_hit = 1'b0; rt_idx = '0; found = 1'b0; sel = '0; cand = '0;
    taken = 1'b0; release_g = 1'b0;
    can_load = !ov_q || out_ready;

    for (int i = N-1; i >= 0; i--)
      if (rt_req[i]) begin rt_hit = 1'b1; rt_idx = IW'(i); end
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr_q) + k) % N);
      if (!found && en_mask[cand] && nrt_vld[cand]) begin found = 1'b1; sel = cand; end
    end

    // Realtime wins the output slot in every state and leaves the message machinery alone.
    if (can_load && rt_hit) begin
      ld = 1'b1; ld_byte = din[rt_idx]; rdy[rt_idx] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (can_load && !rt_hit && found) begin
          rr_d = (sel == IW'(N-1)) ? '0 : sel + 1'b1;
          if (is_stat[sel]) begin
            ld = 1'b1; ld_byte = din[sel]; rdy[sel] = 1'b1;
            if (din[sel] == 8'hF0) begin
              state_d = S_SYSEX; grant_d = '0; grant_d[sel] = 1'b1; gidx_d = sel;
            end else if (data_need(din[sel]) != 2'd0) begin
              state_d = S_FWD; cnt_d = data_need(din[sel]);
              grant_d = '0; grant_d[sel] = 1'b1; gidx_d = sel;
            end
          end else if (rs[sel] != 8'h00) begin
            state_d = S_INSERT; grant_d = '0; grant_d[sel] = 1'b1; gidx_d = sel;
          end else begin
            rdy[sel] = 1'b1;  // orphan data with no running status is dropped
          end
        end
      end
      default: begin
        if (can_load && !rt_hit) begin
          case (state_q)
            S_INSERT: begin
              ld = 1'b1; ld_byte = rs[gidx_q];
              cnt_d = data_need(rs[gidx_q]); state_d = S_FWD;
            end
            S_FWD: begin
              if (nrt_vld[gidx_q]) begin
                if (is_stat[gidx_q]) release_g = 1'b1;
                else begin
                  ld = 1'b1; ld_byte = din[gidx_q]; rdy[gidx_q] = 1'b1; taken = 1'b1;
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == 2'd1) release_g = 1'b1;
                end
              end
            end
            S_SYSEX: begin
              if (nrt_vld[gidx_q]) begin
                if (!is_stat[gidx_q] || din[gidx_q] == 8'hF7) begin
                  ld = 1'b1; ld_byte = din[gidx_q]; rdy[gidx_q] = 1'b1; taken = 1'b1;
                end
                if (is_stat[gidx_q]) release_g = 1'b1;
              end
            end
            default: ;
          endcase
        end
        // A stalled output register does not count against the sender.
        if (can_load) begin
          if (taken) to_d = '0;
          else if (!release_g) begin
            if ((to_q + 1'b1) == TIMEOUT) begin release_g = 1'b1; err_d = 1'b1; end
            else to_d = to_q + 1'b1;
          end
        end
        if (release_g) begin state_d = S_IDLE; grant_d = '0; to_d = '0; end
      end
    endcase

    od_d = ld ? ld_byte : od_q;
    ov_d = ld ? 1'b1 : (out_ready ? 1'b0 : ov_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; grant_q <= '0; gidx_q <= '0; rr_q <= '0;
      cnt_q <= 2'd0; to_q <= '0; err_q <= 1'b0; od_q <= 8'h00; ov_q <= 1'b0;
    end else begin
      state_q <= state_d; grant_q <= grant_d; gidx_q <= gidx_d; rr_q <= rr_d;
      cnt_q <= cnt_d; to_q <= to_d; err_q <= err_d; od_q <= od_d; ov_q <= ov_d;
    end
  end

  assign in_ready    = rdy & {N{rst_n}};
  assign out_data    = od_q;
  assign out_valid   = ov_q;
  assign grant       = grant_q;
  assign err_timeout = err_q;
endmodule
